// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode pipeline control slice.
package pipe_pkg;

  localparam int          CNT_W     = 16;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_decode_pipe_ctrl.sv
// Fetch PC and IF/ID register control: holds on StallD, squashes wrong-path
// fetches after an EX redirect, and tracks stall/flush statistics.
module fetch_decode_pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter logic [31:0]     NOP_INSTR    = pipe_pkg::NOP_INSTR,
  parameter int              FLUSH_CYCLES = 1,
  parameter int              MAX_STALL    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallD,
  input  logic            FlushE,
  input  logic [XLEN-1:0] BranchTargetE,
  input  logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [31:0]     InstrD,
  output logic            ValidD,
  output logic            BubbleE,
  output logic [15:0]     StallCount,
  output logic [15:0]     FlushCount,
  output logic            StallTimeout
);

  localparam int SQ_W  = 2;
  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [SQ_W-1:0]  SQ_RELOAD = SQ_W'(FLUSH_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_STALL + 1);

  state_e            state_q;
  logic [SQ_W-1:0]   squash_q;
  logic [XLEN-1:0]   pcf_q;
  logic [XLEN-1:0]   pcd_q;
  logic [XLEN-1:0]   pcplus4d_q;
  logic [31:0]       instrd_q;
  logic              validd_q;
  logic [RUN_W-1:0]  stall_run_q;
  logic [RUN_W-1:0]  stall_run_d;
  logic              timeout_q;
  logic              timeout_d;
  logic [XLEN-1:0]   pcf_plus4;
  logic              stall_eff;
  logic              unused_tgt_lsb;

  assign pcf_plus4      = pcf_q + XLEN'(4);
  assign stall_eff      = StallD & ~FlushE;
  assign unused_tgt_lsb = ^BranchTargetE[1:0];

  // Priority: redirect, then stall (hold everything), then fetch/squash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      squash_q   <= '0;
      pcf_q      <= RESET_PC;
      pcd_q      <= '0;
      pcplus4d_q <= '0;
      instrd_q   <= NOP_INSTR;
      validd_q   <= 1'b0;
    end else if (FlushE) begin
      pcf_q      <= {BranchTargetE[XLEN-1:2], 2'b00};
      pcd_q      <= '0;
      pcplus4d_q <= '0;
      instrd_q   <= NOP_INSTR;
      validd_q   <= 1'b0;
      squash_q   <= SQ_RELOAD;
      state_q    <= (SQ_RELOAD != '0) ? SQUASH : RUN;
    end else if (!StallD) begin
      pcf_q <= pcf_plus4;
      if (state_q == RUN) begin
        pcd_q      <= pcf_q;
        pcplus4d_q <= pcf_plus4;
        instrd_q   <= InstrF;
        validd_q   <= 1'b1;
      end else begin
        pcd_q      <= '0;
        pcplus4d_q <= '0;
        instrd_q   <= NOP_INSTR;
        validd_q   <= 1'b0;
        squash_q   <= squash_q - SQ_W'(1);
        state_q    <= (squash_q > SQ_W'(1)) ? SQUASH : RUN;
      end
    end
  end

  // Consecutive-stall tracker; a flush breaks the run just like StallD=0.
  always_comb begin
    stall_run_d = '0;
    if (stall_eff) begin
      stall_run_d = (stall_run_q == RUN_SAT) ? RUN_SAT : stall_run_q + RUN_W'(1);
    end
    timeout_d = timeout_q | (stall_run_d > RUN_W'(MAX_STALL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_run_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_run_q <= stall_run_d;
      timeout_q   <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_eff),
    .clr_i   (1'b0),
    .count_o (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (FlushE),
    .clr_i   (1'b0),
    .count_o (FlushCount)
  );

  assign PCF          = pcf_q;
  assign PCD          = pcd_q;
  assign PCPlus4D     = pcplus4d_q;
  assign InstrD       = instrd_q;
  assign ValidD       = validd_q;
  assign BubbleE      = stall_eff;
  assign StallTimeout = timeout_q;

endmodule

// File: tb/tb_fetch_decode_pipe_ctrl.sv
// Directed scoreboard bench: the driver queues hand-computed post-edge state,
// a monitor pops one entry per rising edge and compares.
module tb_fetch_decode_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        StallD;
  logic        FlushE;
  logic [31:0] BranchTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [31:0] InstrD;
  logic        ValidD;
  logic        BubbleE;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;
  logic        StallTimeout;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  typedef struct {
    logic        chk;
    logic [31:0] pcf;
    logic [31:0] pcd;
    logic [31:0] p4;
    logic [31:0] instr;
    logic        v;
    logic        bub;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];

  fetch_decode_pipe_ctrl #(
    .XLEN         (32),
    .RESET_PC     (32'h0000_0000),
    .NOP_INSTR    (32'h0000_0013),
    .FLUSH_CYCLES (2),
    .MAX_STALL    (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .StallD        (StallD),
    .FlushE        (FlushE),
    .BranchTargetE (BranchTargetE),
    .InstrF        (InstrF),
    .PCF           (PCF),
    .PCD           (PCD),
    .PCPlus4D      (PCPlus4D),
    .InstrD        (InstrD),
    .ValidD        (ValidD),
    .BubbleE       (BubbleE),
    .StallCount    (StallCount),
    .FlushCount    (FlushCount),
    .StallTimeout  (StallTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void cmp(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s (txn %0d): got %h expected %h", name, txn, act, req);
    end
  endfunction

  function automatic exp_t E(logic [31:0] pcf, logic [31:0] pcd, logic [31:0] p4,
                             logic [31:0] instr, logic v, logic bub,
                             logic [15:0] sc, logic [15:0] fc, logic tmo);
    exp_t e;
    e.chk = 1'b1; e.pcf = pcf; e.pcd = pcd; e.p4 = p4; e.instr = instr;
    e.v = v; e.bub = bub; e.sc = sc; e.fc = fc; e.tmo = tmo;
    return e;
  endfunction

  function automatic void check_all(exp_t e);
    cmp("PCF",          PCF,                   e.pcf);
    cmp("PCD",          PCD,                   e.pcd);
    cmp("PCPlus4D",     PCPlus4D,              e.p4);
    cmp("InstrD",       InstrD,                e.instr);
    cmp("ValidD",       {31'd0, ValidD},       {31'd0, e.v});
    cmp("BubbleE",      {31'd0, BubbleE},      {31'd0, e.bub});
    cmp("StallCount",   {16'd0, StallCount},   {16'd0, e.sc});
    cmp("FlushCount",   {16'd0, FlushCount},   {16'd0, e.fc});
    cmp("StallTimeout", {31'd0, StallTimeout}, {31'd0, e.tmo});
  endfunction

  // Drive one cycle's inputs at a falling edge, queue the state expected after the next rising edge.
  task automatic step(input logic s, input logic f, input logic [31:0] tgt,
                      input logic [31:0] instr, input exp_t e);
    StallD        = s;
    FlushE        = f;
    BranchTargetE = tgt;
    InstrF        = instr;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: inputs are stable from the falling edge, so BubbleE is still valid 1ns after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        txn++;
        if (e.chk) begin
          check_all(e);
          $display("txn %0d: PCF=%h PCD=%h InstrD=%h ValidD=%b BubbleE=%b SC=%h FC=%h TO=%b",
                   txn, PCF, PCD, InstrD, ValidD, BubbleE, StallCount, FlushCount, StallTimeout);
        end
      end
    end
  end

  initial begin
    exp_t skip;
    skip     = E(0, 0, 0, 0, 0, 0, 0, 0, 0);
    skip.chk = 1'b0;

    rst = 1'b1; StallD = 1'b0; FlushE = 1'b0; BranchTargetE = '0; InstrF = '0;
    repeat (2) @(negedge clk);
    check_all(E(32'h0, 32'h0, 32'h0, 32'h13, 0, 0, 0, 0, 0));
    $display("reset: PCF=%h InstrD=%h ValidD=%b", PCF, InstrD, ValidD);
    rst = 1'b0;

    // free fetch, 2-cycle stall, resume
    step(0, 0, 0, 32'hA, E(32'h4, 32'h0, 32'h4, 32'hA, 1, 0, 0, 0, 0));
    step(0, 0, 0, 32'hB, E(32'h8, 32'h4, 32'h8, 32'hB, 1, 0, 0, 0, 0));
    step(1, 0, 0, 32'hC, E(32'h8, 32'h4, 32'h8, 32'hB, 1, 1, 1, 0, 0));
    step(1, 0, 0, 32'hC, E(32'h8, 32'h4, 32'h8, 32'hB, 1, 1, 2, 0, 0));
    step(0, 0, 0, 32'hC, E(32'hC, 32'h8, 32'hC, 32'hC, 1, 0, 2, 0, 0));

    // redirect to 0x103 -> 0x100, two squashed slots, first valid is the 0x104 word
    step(0, 1, 32'h103, 32'hD,    E(32'h100, 32'h0,   32'h0,   32'h13,   0, 0, 2, 1, 0));
    step(0, 0, 0,       32'h1000, E(32'h104, 32'h0,   32'h0,   32'h13,   0, 0, 2, 1, 0));
    step(0, 0, 0,       32'h1040, E(32'h108, 32'h104, 32'h108, 32'h1040, 1, 0, 2, 1, 0));

    // flush and stall together: flush wins; then a stall while squashing holds
    step(1, 1, 32'h200, 32'h1080, E(32'h200, 32'h0,   32'h0,   32'h13,   0, 0, 2, 2, 0));
    step(1, 0, 0,       32'h2000, E(32'h200, 32'h0,   32'h0,   32'h13,   0, 1, 3, 2, 0));
    step(0, 0, 0,       32'h2000, E(32'h204, 32'h0,   32'h0,   32'h13,   0, 0, 3, 2, 0));
    step(0, 0, 0,       32'h2040, E(32'h208, 32'h204, 32'h208, 32'h2040, 1, 0, 3, 2, 0));

    // nine consecutive stalls: timeout appears only after the ninth
    for (int k = 1; k <= 9; k++) begin
      step(1, 0, 0, 32'h2080,
           E(32'h208, 32'h204, 32'h208, 32'h2040, 1, 1, 16'(3 + k), 2, (k == 9)));
    end
    step(0, 0, 0, 32'h2080, E(32'h20C, 32'h208, 32'h20C, 32'h2080, 1, 0, 12, 2, 1));
    step(1, 0, 0, 32'h2090, E(32'h20C, 32'h208, 32'h20C, 32'h2080, 1, 1, 13, 2, 1));

    // asynchronous reset in the middle of a stall cycle
    #2 rst = 1'b1;
    #1;
    check_all(E(32'h0, 32'h0, 32'h0, 32'h13, 0, 1, 0, 0, 0));
    $display("async reset: PCF=%h StallCount=%h StallTimeout=%b", PCF, StallCount, StallTimeout);
    @(negedge clk);
    rst = 1'b0;

    // PC and PC+4 wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFB, 32'h3, E(32'hFFFF_FFF8, 32'h0, 32'h0, 32'h13, 0, 0, 0, 1, 0));
    step(0, 0, 0, 32'h3000, E(32'hFFFF_FFFC, 32'h0,          32'h0, 32'h13,   0, 0, 0, 1, 0));
    step(0, 0, 0, 32'h3000, E(32'h0,         32'hFFFF_FFFC,  32'h0, 32'h3000, 1, 0, 0, 1, 0));
    step(0, 0, 0, 32'h3004, E(32'h4,         32'h0,          32'h4, 32'h3004, 1, 0, 0, 1, 0));

    // drive the stall counter to its ceiling, then past it
    for (int i = 0; i < 65534; i++) begin
      step(1, 0, 0, 32'h3008, skip);
    end
    step(1, 0, 0, 32'h3008, E(32'h4, 32'h0, 32'h4, 32'h3004, 1, 1, 16'hFFFF, 1, 1));
    step(1, 0, 0, 32'h3008, E(32'h4, 32'h0, 32'h4, 32'h3004, 1, 1, 16'hFFFF, 1, 1));

    StallD = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
